// File: rtl/dvbs2_mapper_table_ram.sv
// dvbs2_mapper_table_ram
//
// Constellation table for the DVB-S2 bit mapper. Software writes and reads
// the table through the regmap memory port (byte-enabled writes, 1-cycle
// registered reads). The bit mapper datapath looks up words through a
// valid/ready request stream and gets results on a valid/ready output
// stream. Out-of-range addresses write nothing and read 0.
//
// Optional feature, macro DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN:
//   defined   - two banks; the regmap port sees the shadow bank, the datapath
//               the active bank; commit_req arms a swap that takes effect
//               only between frames.
//   undefined - one bank shared by both ports; commit_req is ignored and
//               swap_pending / active_bank read 0.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   regs_addr/wdata/wen/rdata   regmap memory port
//   commit_req                  one-cycle request to publish the shadow table
//   lkp_valid/ready/addr/last   lookup request stream (last = end of frame)
//   dout_valid/ready/data/last  lookup result stream
//   swap_pending                commit armed, not yet applied
//   active_bank                 bank currently read by the datapath
module dvbs2_mapper_table_ram #(
  parameter int DEPTH      = 240,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   regs_addr,
  input  logic [DATA_WIDTH-1:0]   regs_wdata,
  input  logic [DATA_WIDTH/8-1:0] regs_wen,
  output logic [DATA_WIDTH-1:0]   regs_rdata,
  input  logic                    commit_req,
  input  logic                    lkp_valid,
  output logic                    lkp_ready,
  input  logic [ADDR_WIDTH-1:0]   lkp_addr,
  input  logic                    lkp_last,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [DATA_WIDTH-1:0]   dout_data,
  output logic                    dout_last,
  output logic                    swap_pending,
  output logic                    active_bank
);

  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;

  logic                  regs_in_range;
  logic                  lkp_in_range;
  logic                  lkp_accept;
  logic [DATA_WIDTH-1:0] regs_word;
  logic [DATA_WIDTH-1:0] lkp_word;

  logic [DATA_WIDTH-1:0] regs_rdata_q, regs_rdata_d;
  logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  dout_last_q, dout_last_d;
  logic                  in_frame_q, in_frame_d;
  logic                  active_bank_q, active_bank_d;
  swap_state_e           state_q, state_d;

  // Extra MSB so the compare stays correct even if DEPTH == 2**ADDR_WIDTH.
  assign regs_in_range = ({1'b0, regs_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign lkp_in_range  = ({1'b0, lkp_addr} < (ADDR_WIDTH + 1)'(DEPTH));

  assign lkp_ready  = !dout_valid_q || dout_ready;
  assign lkp_accept = lkp_valid && lkp_ready;

`ifdef DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN
  logic [DATA_WIDTH-1:0] table_mem [2][DEPTH];
  logic                  shadow_bank;

  assign shadow_bank = ~active_bank_q;

  // Asynchronous array reads sampled into registers at the edge give
  // read-before-write for both ports: a same-cycle write lands afterwards.
  always_comb begin
    regs_word = '0;
    lkp_word  = '0;
    if (regs_in_range) regs_word = table_mem[shadow_bank][regs_addr];
    if (lkp_in_range)  lkp_word  = table_mem[active_bank_q][lkp_addr];
  end

  // NOTE: table storage has no reset; clearing a RAM would force it into
  // flops and software always loads the table before use.
  always_ff @(posedge clk) begin
    if (regs_in_range) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (regs_wen[b]) table_mem[shadow_bank][regs_addr][8*b +: 8] <= regs_wdata[8*b +: 8];
      end
    end
  end
`else
  logic [DATA_WIDTH-1:0] table_mem [DEPTH];
  logic                  unused_inputs;

  // Single bank: no swap machinery, so these are intentionally unread.
  assign unused_inputs = ^{commit_req, in_frame_q};

  always_comb begin
    regs_word = '0;
    lkp_word  = '0;
    if (regs_in_range) regs_word = table_mem[regs_addr];
    if (lkp_in_range)  lkp_word  = table_mem[lkp_addr];
  end

  always_ff @(posedge clk) begin
    if (regs_in_range) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (regs_wen[b]) table_mem[regs_addr][8*b +: 8] <= regs_wdata[8*b +: 8];
      end
    end
  end
`endif

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    regs_rdata_d  = regs_word;
    dout_valid_d  = dout_valid_q;
    dout_data_d   = dout_data_q;
    dout_last_d   = dout_last_q;
    in_frame_d    = in_frame_q;
    state_d       = state_q;
    active_bank_d = active_bank_q;

    if (lkp_accept) begin
      dout_valid_d = 1'b1;
      dout_data_d  = lkp_word;
      dout_last_d  = lkp_last;
      in_frame_d   = !lkp_last;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end

`ifdef DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN
    // Swap only between frames. An accepted last lookup does not block it;
    // any lookup accepted in the swap cycle still reads the old bank.
    case (state_q)
      ST_IDLE: begin
        if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (!in_frame_q && !(lkp_accept && !lkp_last)) begin
          state_d       = ST_IDLE;
          active_bank_d = ~active_bank_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_rdata_q  <= '0;
      dout_valid_q  <= 1'b0;
      dout_data_q   <= '0;
      dout_last_q   <= 1'b0;
      in_frame_q    <= 1'b0;
      state_q       <= ST_IDLE;
      active_bank_q <= 1'b0;
    end else begin
      regs_rdata_q  <= regs_rdata_d;
      dout_valid_q  <= dout_valid_d;
      dout_data_q   <= dout_data_d;
      dout_last_q   <= dout_last_d;
      in_frame_q    <= in_frame_d;
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
    end
  end

  assign regs_rdata   = regs_rdata_q;
  assign dout_valid   = dout_valid_q;
  assign dout_data    = dout_data_q;
  assign dout_last    = dout_last_q;
  assign swap_pending = (state_q == ST_PENDING);
  assign active_bank  = active_bank_q;

endmodule

// File: tb/tb_dvbs2_mapper_table_ram.sv
// Self-checking bench for dvbs2_mapper_table_ram. Stimulus pushes expected
// lookup results and regmap read data into queues; a monitor on the falling
// edge pops and compares whenever the DUT delivers a result.
`timescale 1ns/1ps
module tb_dvbs2_mapper_table_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  regs_addr;
  logic [31:0] regs_wdata;
  logic [3:0]  regs_wen;
  logic [31:0] regs_rdata;
  logic        commit_req;
  logic        lkp_valid;
  logic        lkp_ready;
  logic [7:0]  lkp_addr;
  logic        lkp_last;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        swap_pending;
  logic        active_bank;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic        rd_issue = 1'b0;
  logic        rd_flag  = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  dvbs2_mapper_table_ram #(
    .DEPTH(240), .ADDR_WIDTH(8), .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .regs_addr   (regs_addr),
    .regs_wdata  (regs_wdata),
    .regs_wen    (regs_wen),
    .regs_rdata  (regs_rdata),
    .commit_req  (commit_req),
    .lkp_valid   (lkp_valid),
    .lkp_ready   (lkp_ready),
    .lkp_addr    (lkp_addr),
    .lkp_last    (lkp_last),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_data   (dout_data),
    .dout_last   (dout_last),
    .swap_pending(swap_pending),
    .active_bank (active_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] w);
    regs_addr  = a;
    regs_wdata = d;
    regs_wen   = w;
    step();
    regs_wen   = '0;
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [31:0] e);
    regs_addr = a;
    rd_q.push_back(e);
    rd_issue  = 1'b1;
    step();
    rd_issue  = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] a, input logic l, input logic [31:0] e);
    exp_t x;
    x.data    = e;
    x.last    = l;
    exp_q.push_back(x);
    lkp_addr  = a;
    lkp_last  = l;
    lkp_valid = 1'b1;
    step();
    lkp_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  // Regmap reads have no valid; mark the cycle whose data is due.
  always @(posedge clk) rd_flag <= rd_issue;

  // Monitor: one compare per delivered lookup result / regmap read.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] r;
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL lkp_unexpected: got 0x%08h expected no output", dout_data);
      end else begin
        e = exp_q.pop_front();
        check("lkp_data", dout_data, e.data);
        check("lkp_last", 32'(dout_last), 32'(e.last));
      end
    end
    if (rd_flag) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", regs_rdata);
      end else begin
        r = rd_q.pop_front();
        check("regs_rdata", regs_rdata, r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst        = 1'b1;
    regs_addr  = '0;
    regs_wdata = '0;
    regs_wen   = '0;
    commit_req = 1'b0;
    lkp_valid  = 1'b0;
    lkp_addr   = '0;
    lkp_last   = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_regs_rdata", regs_rdata, 32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_dout_data", dout_data, 32'h0);
    check("rst_dout_last", 32'(dout_last), 32'h0);
    check("rst_swap_pending", 32'(swap_pending), 32'h0);
    check("rst_active_bank", 32'(active_bank), 32'h0);
    check("rst_lkp_ready", 32'(lkp_ready), 32'h1);
    rst = 1'b0;
    step();

    // Byte-enable write, then read back.
    reg_write(8'd3, 32'hA5A5_5A5A, 4'hF);
    reg_write(8'd3, 32'h0000_FF00, 4'h2);
    reg_read(8'd3, 32'hA5A5_FF5A);

    // Out-of-range write dropped, read returns 0.
    reg_write(8'd240, 32'hFFFF_FFFF, 4'hF);
    reg_read(8'd240, 32'h0);

`ifndef DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN
    // Lookup, then 3 stalled cycles with a rewrite of the same word.
    lookup(8'd3, 1'b0, 32'hA5A5_FF5A);
    dout_ready = 1'b0;
    regs_addr  = 8'd3;
    regs_wdata = 32'hDEAD_BEEF;
    regs_wen   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(dout_valid), 32'h1);
      check("stall_data", dout_data, 32'hA5A5_FF5A);
      check("stall_lkp_ready", 32'(lkp_ready), 32'h0);
      step();
      regs_wen = '0;
    end
    dout_ready = 1'b1;
    step();

    // Out-of-range lookup.
    lookup(8'd245, 1'b1, 32'h0);

    // Read-before-write collision, then the new word is visible.
    reg_write(8'd7, 32'h22, 4'hF);
    regs_addr  = 8'd7;
    regs_wdata = 32'h11;
    regs_wen   = 4'hF;
    lookup(8'd7, 1'b0, 32'h22);
    regs_wen   = '0;
    lookup(8'd7, 1'b1, 32'h11);

    // Back-to-back throughput.
    reg_write(8'd10, 32'h1010_0001, 4'hF);
    reg_write(8'd11, 32'h1111_0002, 4'hF);
    reg_write(8'd12, 32'h1212_0003, 4'hF);
    lookup(8'd10, 1'b0, 32'h1010_0001);
    lookup(8'd11, 1'b0, 32'h1111_0002);
    lookup(8'd12, 1'b1, 32'h1212_0003);

    // Commit has no effect with a single bank.
    pulse_commit();
    @(negedge clk);
    check("sb_swap_pending", 32'(swap_pending), 32'h0);
    check("sb_active_bank", 32'(active_bank), 32'h0);
    step();
`else
    // Publish bank 1 with addr 0 = 0.
    reg_write(8'd0, 32'h0, 4'hF);
    pulse_commit();
    @(negedge clk);
    check("commit_pending", 32'(swap_pending), 32'h1);
    step();
    @(negedge clk);
    check("first_swap_bank", 32'(active_bank), 32'h1);
    check("first_swap_idle", 32'(swap_pending), 32'h0);
    step();

    // Shadow (bank 0) addr 0 = 1; commit mid-frame is deferred.
    reg_write(8'd0, 32'h1, 4'hF);
    lookup(8'd0, 1'b0, 32'h0);
    pulse_commit();
    @(negedge clk);
    check("mid_frame_pending", 32'(swap_pending), 32'h1);
    check("mid_frame_bank", 32'(active_bank), 32'h1);
    step();
    lookup(8'd0, 1'b0, 32'h0);
    lookup(8'd0, 1'b1, 32'h0);
    // Swap cycle: this lookup still reads the old bank.
    lookup(8'd0, 1'b1, 32'h0);
    @(negedge clk);
    check("swap_bank", 32'(active_bank), 32'h0);
    check("swap_idle", 32'(swap_pending), 32'h0);
    step();
    lookup(8'd0, 1'b1, 32'h1);
    // Shadow now holds the previous table.
    reg_read(8'd0, 32'h0);
`endif

    // Reset while a result is stalled (and, if double-buffered, a commit armed).
    step();
    dout_ready = 1'b0;
    lookup(8'd245, 1'b0, 32'h0);
`ifdef DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN
    pulse_commit();
    @(negedge clk);
    check("pre_rst_pending", 32'(swap_pending), 32'h1);
    step();
`endif
    @(negedge clk);
    check("pre_rst_valid", 32'(dout_valid), 32'h1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_dout_valid", 32'(dout_valid), 32'h0);
    check("mid_rst_dout_data", dout_data, 32'h0);
    check("mid_rst_dout_last", 32'(dout_last), 32'h0);
    check("mid_rst_regs_rdata", regs_rdata, 32'h0);
    check("mid_rst_swap_pending", 32'(swap_pending), 32'h0);
    check("mid_rst_active_bank", 32'(active_bank), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    check("post_rst_swap_pending", 32'(swap_pending), 32'h0);
    check("post_rst_dout_valid", 32'(dout_valid), 32'h0);

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size() + rd_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dvbs2_mapper_table_ram.md
# dvbs2_mapper_table_ram

User-logic responder for the regmap's `bit_mapper_ram` memory port: holds the 240 x 32-bit constellation table written and read back over the regmap's addr/wdata/byte-wen/rdata interface. It also serves table lookups to the bit mapper datapath through a valid/ready stream. It sits between the regmap (`regs2user`/`user2regs` memory fields) and the bit mapper. Optionally it double-buffers the table so that software updates take effect only on a frame boundary.

## Interface
- `DEPTH`, 240, number of table words; addresses >= DEPTH are out of range.
- `ADDR_WIDTH`, 8, address width on both ports.
- `DATA_WIDTH`, 32, word width; must be a multiple of 8.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `regs_addr` in ADDR_WIDTH: regmap read/write address.
- `regs_wdata` in DATA_WIDTH: regmap write data.
- `regs_wen` in DATA_WIDTH/8: byte-wide write enables; bit i covers bits [8i+7:8i].
- `regs_rdata` out DATA_WIDTH: regmap read data, 1-cycle latency.
- `commit_req` in 1: single-cycle request to publish the shadow table; driven by `config_strobe`.
- `lkp_valid` in 1, `lkp_ready` out 1, `lkp_addr` in ADDR_WIDTH, `lkp_last` in 1: lookup request stream; `lkp_last` marks the last lookup of a frame.
- `dout_valid` out 1, `dout_ready` in 1, `dout_data` out DATA_WIDTH, `dout_last` out 1: lookup result stream.
- `swap_pending` out 1: a commit is armed and has not yet taken effect.
- `active_bank` out 1: index of the bank the datapath currently reads.

## Operation
- **Regmap port**
  - Every cycle, `regs_rdata` registers the regmap-view word at `regs_addr`.
  - When any `regs_wen` bit is set and the address is in range, only the enabled bytes of that word are written.
  - Out-of-range writes are dropped; out-of-range reads return 0.
  - A write and a read of the same address in the same cycle return the old word (read-before-write).
- **Lookup port**
  - A lookup is accepted when `lkp_valid && lkp_ready`.
  - `lkp_ready = !dout_valid || dout_ready`.
  - On acceptance: `dout_data` is loaded with the active-bank word at `lkp_addr` (0 if out of range), `dout_last` is loaded with `lkp_last`, and `dout_valid` is set.
  - `dout_valid` clears when `dout_ready` is high and no new lookup is accepted.
  - While `dout_valid && !dout_ready`, `dout_data` and `dout_last` hold, even if the table word is rewritten.
- **Frame tracking**
  - `in_frame` sets on an accepted lookup with `!lkp_last`.
  - `in_frame` clears on an accepted lookup with `lkp_last`.
- **Collision**: a regmap write to the datapath-visible word in the same cycle as an accepted lookup of the same address returns the old word to the datapath.

## Timing
- Reset values: `regs_rdata`=0, `dout_valid`=0, `dout_data`=0, `dout_last`=0, `swap_pending`=0, `active_bank`=0, `in_frame`=0. RAM contents are not reset.
- Latency:
  - Regmap read: 1 cycle.
  - Lookup: data valid in the cycle after acceptance.
  - Throughput: 1 lookup per cycle when `dout_ready` is held high.
- Swap FSM (double buffer only), states IDLE and PENDING:
  - IDLE -> PENDING on `commit_req`. From PENDING, the swap happens in the first cycle with `!in_frame` and no accepted non-last lookup.
  - A swap taken in the cycle `lkp_last` is accepted is allowed.
  - Swap effect: toggle `active_bank`, return to IDLE.
  - `commit_req` while in PENDING is absorbed; there is no queueing.
  - A lookup accepted in the swap cycle reads the old bank.
- Reset mid-operation: all state returns to the reset values; a pending commit is lost.

## Configuration
- Macro `DVBS2_MAPPER_TABLE_DOUBLE_BUFFER_EN`.
- Defined:
  - Two banks of DEPTH words.
  - The regmap port reads and writes bank `!active_bank` (the shadow).
  - The datapath reads `active_bank`.
  - After a swap, the shadow holds the previous table; software rewrites the full table before the next commit.
- Undefined:
  - One bank, shared by both ports.
  - `commit_req` is ignored; `swap_pending` and `active_bank` are tied to 0.
  - Regmap writes are visible to the next accepted lookup.

## Test plan
- **Byte-enable write:** write addr 3 = 0xA5A55A5A with `regs_wen`=0xF, then write addr 3 = 0x0000FF00 with `regs_wen`=0x2. Expect `regs_rdata`=0xA5A5FF5A one cycle after addressing 3.
- **Lookup and backpressure (single bank):**
  - Lookup addr 3 with `dout_ready`=1: `dout_valid` and `dout_data`=0xA5A5FF5A in the next cycle.
  - Then hold `dout_ready`=0 for 3 cycles: data held, `lkp_ready`=0 for those 3 cycles.
- **Out of range:** write addr 240 = 0xFFFFFFFF, then read addr 240 -> 0. Lookup addr 245 -> `dout_data`=0.
- **Read-before-write:** in the same cycle, write addr 7 = 0x11 (old 0x22) and accept a lookup of addr 7. Expect `dout_data`=0x22; the next lookup of addr 7 returns 0x11.
- **Deferred commit (double buffer):**
  - Shadow addr 0 = 1, active addr 0 = 0.
  - Pulse `commit_req` mid-frame: `swap_pending`=1, lookups keep returning 0.
  - `lkp_last` accepted -> `active_bank` toggles; the next lookup of addr 0 returns 1.
- **Reset mid-operation:** assert `rst` with `swap_pending`=1 and `dout_valid` held stalled. All outputs return to their reset values and `swap_pending`=0.
